stream_mux_rr: RTL
==================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit multiplexer with valid/ready handshakes on every input and on the output.
- Two modes: fixed (software `sel` chooses the channel, as in the combinational 4:1 mux) and round-robin (fair arbitration across valid channels).
- One registered output stage. Sits between producer channels and a single downstream consumer in datapath test structures.

Parameters:
- WIDTH, 8: data width per channel.
- NCH, 4: number of input channels, 2..16.
- SELW, 2: channel-index width; must equal clog2(NCH). Set by the instantiator.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NCH*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel valid
- in_ready  output  NCH  per-channel ready (combinational)
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel index used in fixed mode
- out_data  output  WIDTH  registered data
- out_chan  output  SELW  registered index of the channel that supplied out_data
- out_valid  output  1  registered valid
- out_ready  input  1  downstream ready

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_data=0, out_chan=0, out_valid=0, rr pointer ptr=0. in_ready is all-zero while rst_n=0.
- load_en = !out_valid || out_ready. The output register accepts new data only when load_en=1.
- Grant (combinational, every cycle):
  - mode=0: gnt_vld = (sel < NCH) && in_valid[sel]; gnt = sel. If sel >= NCH, there is never a grant.
  - mode=1: gnt = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1. gnt_vld = |in_valid.
- in_ready[i] = load_en && gnt_vld && (gnt==i). At most one bit of in_ready is high. in_ready must not depend on out_valid of the same cycle except through load_en.
- Transfer on a clock edge where load_en && gnt_vld:
  - out_data <= channel gnt; out_chan <= gnt; out_valid <= 1.
  - Round-robin: ptr <= (gnt==NCH-1) ? 0 : gnt+1.
- load_en && !gnt_vld: out_valid <= 0; out_data and out_chan hold.
- !load_en (out_valid=1, out_ready=0): out_data, out_chan and out_valid hold stable; in_ready=0.
- Latency: 1 cycle from the input handshake to out_valid.
- Throughput: 1 word/cycle while out_ready=1.
- ptr updates only on round-robin transfers. Fixed-mode transfers leave ptr unchanged.
- Mode or sel changes take effect in the same cycle's grant. A word already held in the output register is unaffected.
- Simultaneous output pop and input push: both occur in the same cycle, with no bubble.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). Any held word is lost. ptr returns to 0.
- No data-dependent arithmetic. The index wrap is the only modular operation.

Test Plan:
- Reset mid-stream: assert rst_n=0 while out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately, before the next edge. After release, in round-robin mode with all 4 valid, first grant is ch0.
- Fixed mode: mode=0, sel=2, in_valid=4'b1111, data ch0..3 = 8'h10, 8'h20, 8'h30, 8'h40, out_ready=1 -> in_ready=4'b0100 every cycle; out_data=8'h30, out_chan=2 one cycle after the first handshake.
- Fixed mode, idle channel: mode=0, sel=1, in_valid=4'b1101 -> in_ready=0. out_valid falls to 0 the cycle after the last word is consumed.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3; in_ready one-hot and rotating.
- Round-robin skip: mode=1, in_valid=4'b1010 -> out_chan alternates 1,3,1,3. Then set in_valid=4'b0001 -> next grant is ch0 and ptr becomes 1.
- Backpressure: out_valid=1 with out_data=8'h20, out_ready=0 for 3 cycles -> out_data stays 8'h20 and in_ready=0. Raise out_ready -> the next word loads in that same cycle (no bubble).

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed-select or round-robin arbitration
// feeding a single registered output stage.
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_chan,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load_en;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt;
    logic [SELW:0]    rr_idx;
    logic [WIDTH-1:0] gnt_data;

    assign load_en = !out_valid_q || out_ready;

    // Round-robin scans from the highest offset down so the channel closest to ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        rr_idx  = '0;
        if (mode) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                rr_idx = {1'b0, ptr_q} + (SELW + 1)'(k);
                if (rr_idx >= (SELW + 1)'(NCH)) begin
                    rr_idx = rr_idx - (SELW + 1)'(NCH);
                end
                for (int i = 0; i < NCH; i++) begin
                    if (rr_idx == (SELW + 1)'(i) && in_valid[i]) begin
                        gnt     = SELW'(i);
                        gnt_vld = 1'b1;
                    end
                end
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    gnt     = SELW'(i);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
            in_ready[i] = rst_n && load_en && gnt_vld && (gnt == SELW'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (gnt_vld) begin
                out_data_d  = gnt_data;
                out_chan_d  = gnt;
                out_valid_d = 1'b1;
                if (mode) begin
                    ptr_d = (gnt == SELW'(NCH - 1)) ? '0 : gnt + SELW'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule
